ring_edge_counter: RTL and testbench
====================================

# ring_edge_counter

Measurement back-end for the instrumented adder's ring path. The block enables the ring and waits a fixed settle time. It then counts rising edges of the adder's `chain_out` over a programmable window of `wb_clk_i` cycles and hands the count to the wishbone/logic-analyser readout through a valid/ready handshake. It sits directly downstream of the instrumented adder and upstream of the LA register map.

## Interface

Parameters:
- `COUNT_W`, default 32: width of the edge count.
- `WINDOW_W`, default 16: width of the window-length field.
- `SETTLE_CYCLES`, default 4: cycles between ring enable and the start of counting. Must be ≥1.

Ports:
- `wb_clk_i`  in  1  single clock for all logic.
- `wb_rst_ni`  in  1  asynchronous, active-low reset.
- `ring_in`  in  1  `chain_out` from the instrumented adder; asynchronous to `wb_clk_i`.
- `start`  in  1  one-cycle request to begin a measurement.
- `abort`  in  1  cancel the current measurement.
- `window_len`  in  WINDOW_W  count window in clock cycles; sampled when `start` is accepted.
- `ring_en`  out  1  enable to the adder ring; high in SETTLE and COUNT only.
- `busy`  out  1  high in every state except IDLE.
- `result`  out  COUNT_W  edge count; held stable while `result_valid` is high.
- `overflow`  out  1  count exceeded 2^COUNT_W−1 during the window; qualified by `result_valid`.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer accepts the result.

## Operation

- FSM states: IDLE, SETTLE, COUNT, DONE.
  - IDLE→SETTLE on `start`. This latches `window_len` and clears the counter and `overflow`.
  - SETTLE→COUNT after SETTLE_CYCLES cycles. If the latched window is 0, SETTLE→DONE instead, with result 0.
  - COUNT→DONE after exactly window-length cycles in COUNT.
  - DONE→IDLE on the cycle where `result_valid && result_ready`.
- `abort` moves SETTLE or COUNT to IDLE. The count is discarded and `result_valid` is never raised for that run.
- `abort` has no effect in IDLE or DONE.
- `abort` has priority over `start` in the same cycle: `start` is ignored.
- `start` outside IDLE is ignored; it is never queued.
- `ring_in` passes through a 2-flop synchronizer, then a rising-edge detector. One detect pulse increments the counter only while in COUNT. Pulses in SETTLE, DONE and IDLE are dropped.
- `ring_in` must be below `wb_clk_i`/4. Faster toggling aliases and is out of spec.
- Overflow handling is set by the Configuration macro.

## Timing

- Reset values: `ring_en`=0, `busy`=0, `result`=0, `overflow`=0, `result_valid`=0, FSM=IDLE. Synchronizer flops are 0.
- Reset mid-measurement returns everything to the reset values immediately (asynchronous). No result is produced.
- Clock edge with `start` high in IDLE = cycle 0. From cycle 1:
  - `ring_en` and `busy` are high.
  - SETTLE lasts cycles 1..SETTLE_CYCLES.
  - COUNT lasts the next N cycles.
  - `result_valid` rises in cycle SETTLE_CYCLES+N+1.
- Synchronizer + edge-detect latency is 3 cycles. A `ring_in` edge within the last 3 cycles of the window is therefore not counted. This is accepted and documented measurement skew.
- `result_valid` and `result` stay stable until the handshake completes. `ready` without `valid` has no effect.
- A new `start` is accepted at the earliest one cycle after the accepting handshake.

## Configuration

- `RING_EDGE_COUNTER_SATURATE_EN` defined: the counter saturates at all-ones. `overflow` sets on the first attempted increment past all-ones.
- Not defined: the counter wraps modulo 2^COUNT_W. `overflow` sets on the first wrap and stays set until the next `start`.

## Structure

- Shared package `ring_edge_counter_pkg` holds:
  - the FSM state enum (`RC_IDLE`, `RC_SETTLE`, `RC_COUNT`, `RC_DONE`);
  - the default width constants.
- One sub-module, `ring_sync_edge`: 2-flop synchronizer plus rising-edge detector with asynchronous active-low reset. Its output is a 1-cycle pulse.
- The top holds the FSM, settle/window down-counter, edge counter and output registers.

## Test plan

- Defaults; `ring_in` toggling with period 8 clocks; `window_len`=64; `start` → `ring_en` high at cycle 1, `result_valid` at cycle 69, `result`=8 ±1, `overflow`=0.
- `window_len`=0 → no COUNT state, `result_valid` at cycle 5, `result`=0, `ring_en` low after cycle 4.
- `abort` in cycle 10 of COUNT → FSM=IDLE next cycle, `ring_en`=0, `busy`=0, `result_valid` never asserted. A following `start` gives a fresh correct count.
- `COUNT_W`=4, period-8 ring, `window_len`=200:
  - with the macro: `result`=15, `overflow`=1;
  - without the macro: `result`=25 mod 16=9 (±1), `overflow`=1.
- `result_ready` held low 20 cycles in DONE while `ring_in` toggles → `result` unchanged; `start` ignored. Ready high → IDLE next cycle.
- `wb_rst_ni` pulsed low during COUNT → all outputs 0 asynchronously; after release, `start` gives a normal measurement.

Source files
------------

// File: rtl/ring_edge_counter_pkg.sv
// Shared types and default widths for the ring edge counter.
package ring_edge_counter_pkg;

    localparam int RC_COUNT_W_DEF       = 32;
    localparam int RC_WINDOW_W_DEF      = 16;
    localparam int RC_SETTLE_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        RC_IDLE   = 2'd0,
        RC_SETTLE = 2'd1,
        RC_COUNT  = 2'd2,
        RC_DONE   = 2'd3
    } rc_state_t;

endpackage

// File: rtl/ring_edge_counter_sync_edge.sv
// Two-flop synchronizer for the asynchronous ring signal followed by a
// registered rising-edge detector producing a one-cycle pulse.
module ring_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic pulse_o
);

    logic sync1_q, sync2_q, prev_q, pulse_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/ring_edge_counter.sv
// Ring-path edge counter: settle, count chain_out edges over a window, hand off.
// Build macro RING_EDGE_COUNTER_SATURATE_EN: saturating count (default wraps).
//
// state     | meaning
// ----------+---------------------------------------------------------
// RC_IDLE   | waiting for start, ring disabled
// RC_SETTLE | ring enabled, waiting SETTLE_CYCLES before counting
// RC_COUNT  | counting synchronized ring edges for window_len cycles
// RC_DONE   | result valid, waiting for result_ready
module ring_edge_counter
    import ring_edge_counter_pkg::*;
#(
    parameter int COUNT_W       = RC_COUNT_W_DEF,
    parameter int WINDOW_W      = RC_WINDOW_W_DEF,
    parameter int SETTLE_CYCLES = RC_SETTLE_CYCLES_DEF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic                ring_in,
    input  logic                start,
    input  logic                abort,
    input  logic [WINDOW_W-1:0] window_len,
    output logic                ring_en,
    output logic                busy,
    output logic [COUNT_W-1:0]  result,
    output logic                overflow,
    output logic                result_valid,
    input  logic                result_ready
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMR_W = (WINDOW_W > SET_W) ? WINDOW_W : SET_W;

    rc_state_t           state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [WINDOW_W-1:0] win_q, win_d;
    logic [COUNT_W-1:0]  cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                edge_pulse;
    logic [COUNT_W:0]    cnt_inc;

    ring_sync_edge u_sync_edge (
        .clk_i  (wb_clk_i),
        .rst_ni (wb_rst_ni),
        .d_i    (ring_in),
        .pulse_o(edge_pulse)
    );

    // Carry out of the increment marks the all-ones count in both modes.
    assign cnt_inc = {1'b0, cnt_q} + {{COUNT_W{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            RC_IDLE: begin
                if (start && !abort) begin
                    state_d = RC_SETTLE;
                    win_d   = window_len;
                    tmr_d   = TMR_W'(SETTLE_CYCLES - 1);
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            RC_SETTLE: begin
                if (abort) begin
                    state_d = RC_IDLE;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else if (tmr_q == '0) begin
                    state_d = (win_q == '0) ? RC_DONE : RC_COUNT;
                    tmr_d   = TMR_W'(win_q) - TMR_W'(1);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            RC_COUNT: begin
                if (abort) begin
                    state_d = RC_IDLE;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    if (edge_pulse) begin
`ifdef RING_EDGE_COUNTER_SATURATE_EN
                        if (cnt_inc[COUNT_W]) ovf_d = 1'b1;
                        else                  cnt_d = cnt_inc[COUNT_W-1:0];
`else
                        cnt_d = cnt_inc[COUNT_W-1:0];
                        if (cnt_inc[COUNT_W]) ovf_d = 1'b1;
`endif
                    end
                    if (tmr_q == '0) state_d = RC_DONE;
                    else             tmr_d   = tmr_q - TMR_W'(1);
                end
            end
            RC_DONE: begin
                if (result_ready) state_d = RC_IDLE;
            end
            default: state_d = RC_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= RC_IDLE;
            tmr_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ring_en      = (state_q == RC_SETTLE) || (state_q == RC_COUNT);
    assign busy         = (state_q != RC_IDLE);
    assign result       = cnt_q;
    assign overflow     = ovf_q;
    assign result_valid = (state_q == RC_DONE);

endmodule

// File: tb/tb_ring_edge_counter.sv
// Randomized bench for ring_edge_counter: a default-width and a 4-bit-count
// instance share stimulus; expected counts come from a ring-edge timeline model.
module tb_ring_edge_counter;

    localparam int S = 4;

    logic        clk = 1'b0, rst_n = 1'b0, ring = 1'b0;
    logic        start = 1'b0, abort = 1'b0, ready = 1'b0;
    logic [15:0] window = '0;
    logic        ren_a, busy_a, ovf_a, val_a;
    logic [31:0] res_a;
    logic        ren_b, busy_b, ovf_b, val_b;
    logic [3:0]  res_b;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, t0 = 0;
    int hp = 4, ph = 4;
    bit ring_on = 1'b0;
    int rises[$];

    always #5 clk = ~clk;

    ring_edge_counter dut_a (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .ring_in(ring), .start(start),
        .abort(abort), .window_len(window), .ring_en(ren_a), .busy(busy_a),
        .result(res_a), .overflow(ovf_a), .result_valid(val_a),
        .result_ready(ready)
    );

    ring_edge_counter #(.COUNT_W(4)) dut_b (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .ring_in(ring), .start(start),
        .abort(abort), .window_len(window), .ring_en(ren_b), .busy(busy_b),
        .result(res_b), .overflow(ovf_b), .result_valid(val_b),
        .result_ready(ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one clock; the ring generator changes ring just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ring_on) begin
            ph--;
            if (ph <= 0) begin
                ring = ~ring;
                ph   = hp;
                if (ring) rises.push_back(cyc);
            end
        end
    endtask

    // A ring rise driven after edge c reaches the counter at edge c+4; it
    // counts if that edge closes one of the window cycles t0+S+1..t0+S+n.
    function automatic int model_count(input int n);
        int k = 0;
        foreach (rises[i])
            if (rises[i] + 4 >= t0 + S + 1 && rises[i] + 4 <= t0 + S + n) k++;
        return k;
    endfunction

    task automatic check_results(input int k);
        int e4;
        chk("result_w32", res_a, k);
        chk("overflow_w32", ovf_a, 0);
`ifdef RING_EDGE_COUNTER_SATURATE_EN
        e4 = (k > 15) ? 15 : k;
`else
        e4 = k % 16;
`endif
        chk("result_w4", res_b, e4);
        chk("overflow_w4", ovf_b, (k > 15) ? 1 : 0);
    endtask

    task automatic measure(input int n, input int abort_at, input int hold);
        int k;
        bit saw;
        window = 16'(n);
        start  = 1'b1;
        rises.delete();
        tick();
        start  = 1'b0;
        window = 16'($urandom);
        t0     = cyc;
        chk("ring_en_cycle1", ren_a, 1);
        chk("busy_cycle1", busy_a, 1);
        if (abort_at >= 0) begin
            while (cyc < t0 + S + abort_at) tick();
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_ring_en", ren_a, 0);
            chk("abort_busy", busy_a, 0);
            chk("abort_busy_w4", busy_b, 0);
            saw = 1'b0;
            repeat (n + S + 2) begin
                tick();
                if (val_a || val_b) saw = 1'b1;
            end
            chk("abort_no_valid", saw, 0);
            return;
        end
        while (cyc < t0 + S + n - 1) tick();
        chk("valid_not_early", val_a, 0);
        tick();
        chk("valid_on_time", val_a, 1);
        chk("valid_on_time_w4", val_b, 1);
        chk("ring_en_done", ren_a, 0);
        k = model_count(n);
        check_results(k);
        for (int i = 0; i < hold; i++) begin
            start = (i == hold / 2);
            tick();
            start = 1'b0;
        end
        if (hold > 0) begin
            chk("held_valid", val_a, 1);
            chk("held_busy", busy_a, 1);
            check_results(k);
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("handshake_valid", val_a, 0);
        chk("handshake_busy", busy_a, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, ab, hd;
        repeat (3) tick();
        chk("rst_ring_en", ren_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_result", res_a, 0);
        chk("rst_overflow", ovf_a, 0);
        chk("rst_valid", val_a, 0);
        chk("rst_result_w4", res_b, 0);
        rst_n = 1'b1;
        tick();

        ready = 1'b1;
        repeat (3) tick();
        ready = 1'b0;
        chk("ready_in_idle", busy_a, 0);

        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_beats_start", busy_a, 0);

        ring_on = 1'b1; hp = 4; ph = 4;
        measure(64, -1, 0);
        measure(0, -1, 2);
        measure(64, 10, 0);
        measure(64, -1, 0);
        measure(200, -1, 0);
        measure(30, -1, 20);

        window = 16'd50; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (S + 5) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ring_en", ren_a, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_result", res_a, 0);
        chk("arst_valid", val_a, 0);
        chk("arst_result_w4", res_b, 0);
        tick();
        rst_n = 1'b1;
        tick();
        measure(40, -1, 0);

        for (int it = 0; it < 12; it++) begin
            hp = $urandom_range(3, 7);
            n  = $urandom_range(0, 120);
            ab = (n > 3 && ($urandom % 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            hd = $urandom_range(0, 6);
            measure(n, ab, hd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
